// File: rtl/muldiv_iter.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring shift-subtract step per cycle.
// Optional MULDIV_EARLY_OUT_EN: trivial operands (divide by zero, signed overflow, zero multiply) finish in one cycle.
module muldiv_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CNT_W = (XLEN > 1) ? $clog2(XLEN) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = '1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;

    logic [2:0]        op_q;
    logic [XLEN-1:0]   acc;
    logic [XLEN-1:0]   lo;
    logic [XLEN-1:0]   dvs;
    logic              neg_res;
    logic              neg_rem;
    logic              div_zero;
    logic              div_ovf;
    logic [XLEN-1:0]   a_save;

    logic              a_signed;
    logic              b_signed;
    logic              a_neg;
    logic              b_neg;
    logic              ovf_in;
    logic              accept;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;

    logic [XLEN:0]     sum;
    logic [XLEN:0]     rem_shift;
    logic [XLEN:0]     diff;
    logic [XLEN-1:0]   acc_nxt;
    logic [XLEN-1:0]   lo_nxt;

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   final_res;

    function automatic logic [XLEN-1:0] neg_if(input logic n, input logic [XLEN-1:0] v);
        return n ? -v : v;
    endfunction

    function automatic logic [2*XLEN-1:0] neg_wide(input logic n, input logic [2*XLEN-1:0] v);
        return n ? -v : v;
    endfunction

    always_comb begin
        a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                   (funct3 == 3'b100) || (funct3 == 3'b110);
        b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
        a_neg    = a_signed & op_a[XLEN-1];
        b_neg    = b_signed & op_b[XLEN-1];
        a_mag    = neg_if(a_neg, op_a);
        b_mag    = neg_if(b_neg, op_b);
        ovf_in   = funct3[2] && b_signed && (op_a == MOST_NEG) && (op_b == ALL_ONES);
        accept   = start && (state != CALC);
    end

    // Multiply keeps the product in {acc, lo} and shifts right; divide shifts the
    // dividend out of lo into acc while quotient bits shift in at lo[0].
    always_comb begin
        sum       = {1'b0, acc} + (lo[0] ? {1'b0, dvs} : '0);
        rem_shift = {acc, lo[XLEN-1]};
        diff      = rem_shift - {1'b0, dvs};
        if (op_q[2]) begin
            acc_nxt = diff[XLEN] ? rem_shift[XLEN-1:0] : diff[XLEN-1:0];
            lo_nxt  = {lo[XLEN-2:0], ~diff[XLEN]};
        end else begin
            acc_nxt = sum[XLEN:1];
            lo_nxt  = {sum[0], lo[XLEN-1:1]};
        end
    end

    // Result is formed from the last step's outputs so it can be registered on the edge entering DONE.
    always_comb begin
        prod = neg_wide(neg_res, {acc_nxt, lo_nxt});
        quo  = neg_if(neg_res, lo_nxt);
        rem  = neg_if(neg_rem, acc_nxt);
        case (op_q)
            3'b000:                final_res = prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: final_res = prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:        final_res = div_zero ? ALL_ONES : (div_ovf ? MOST_NEG : quo);
            default:               final_res = div_zero ? a_save : (div_ovf ? '0 : rem);
        endcase
    end

`ifdef MULDIV_EARLY_OUT_EN
    logic            trivial;
    logic [XLEN-1:0] trivial_res;

    always_comb begin
        trivial     = 1'b0;
        trivial_res = '0;
        if (funct3[2]) begin
            if (op_b == '0) begin
                trivial     = 1'b1;
                trivial_res = funct3[1] ? op_a : ALL_ONES;
            end else if (ovf_in) begin
                trivial     = 1'b1;
                trivial_res = funct3[1] ? '0 : MOST_NEG;
            end
        end else if ((op_a == '0) || (op_b == '0)) begin
            trivial = 1'b1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (accept) begin
            op_q     <= funct3;
            acc      <= '0;
            lo       <= a_mag;
            dvs      <= b_mag;
            neg_res  <= a_neg ^ b_neg;
            neg_rem  <= a_neg;
            div_zero <= (op_b == '0);
            div_ovf  <= ovf_in;
            a_save   <= op_a;
        end else if (state == CALC) begin
            acc <= acc_nxt;
            lo  <= lo_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
`ifdef MULDIV_EARLY_OUT_EN
                        if (trivial) begin
                            state  <= DONE;
                            done   <= 1'b1;
                            result <= trivial_res;
                        end else
`endif
                        begin
                            state <= CALC;
                            busy  <= 1'b1;
                            cnt   <= '0;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    if (cnt == LAST) begin
                        state  <= DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        result <= final_res;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_iter.sv
// Directed bench for muldiv_iter at XLEN=32: results, latency, back-to-back issue, special cases, reset.
module tb_muldiv_iter;

`ifdef MULDIV_EARLY_OUT_EN
    localparam int EO_LAT = 1;
`else
    localparam int EO_LAT = 33;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    muldiv_iter #(.XLEN(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Operands are scrambled after acceptance so a unit that re-reads them would be caught.
    task automatic launch(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        funct3 = f;
        op_a   = a;
        op_b   = b;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        funct3 = ~f;
        op_a   = 32'h1357_9BDF;
        op_b   = 32'h2468_ACE0;
    endtask

    task automatic wait_done(input int c0, output int lat, output logic busy_ok);
        lat     = c0;
        busy_ok = 1'b1;
        while (!done && lat < 100) begin
            if (!busy) busy_ok = 1'b0;
            tick();
            lat++;
        end
    endtask

    task automatic run(input string tag, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int   lat;
        logic bz;
        launch(f, a, b);
        wait_done(1, lat, bz);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_res"}, result, exp_res);
        check({tag, "_busy_done"}, {31'b0, busy}, 32'd0);
        if (exp_lat > 1) check({tag, "_busy_calc"}, {31'b0, bz}, 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int   lat;
        int   seen;
        logic bz;

        #12;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_result", result, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        run("mul", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        tick();
        check("idle_done", {31'b0, done}, 32'd0);
        check("idle_busy", {31'b0, busy}, 32'd0);
        check("idle_hold", result, 32'hFFFF_FFEB);

        run("mulh", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
        run("mulh_neg", 3'b001, 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFFF, 33);
        run("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
        run("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        tick();

        // Back-to-back: each next op is launched in the previous DONE cycle.
        run("div", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        run("rem", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        run("divu", 3'b101, 32'd100, 32'd7, 32'd14, 33);
        run("remu", 3'b111, 32'd100, 32'd7, 32'd2, 33);
        run("divu_max", 3'b101, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33);
        tick();

        run("div_zero", 3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, EO_LAT);
        run("rem_zero", 3'b110, 32'd5, 32'd0, 32'd5, EO_LAT);
        run("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, EO_LAT);
        run("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, EO_LAT);
        tick();
        run("eo_divu", 3'b101, 32'd9, 32'd0, 32'hFFFF_FFFF, EO_LAT);
        tick();
        run("eo_mul", 3'b000, 32'd0, 32'd1234, 32'd0, EO_LAT);
        tick();

        launch(3'b101, 32'd100, 32'd7);
        repeat (9) tick();
        funct3 = 3'b000;
        op_a   = 32'd3;
        op_b   = 32'd3;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        wait_done(11, lat, bz);
        check("ign_lat", 32'(lat), 32'd33);
        check("ign_res", result, 32'd14);
        check("ign_busy", {31'b0, bz}, 32'd1);
        tick();

        launch(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (11) tick();
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", {31'b0, busy}, 32'd0);
        check("mid_rst_done", {31'b0, done}, 32'd0);
        check("mid_rst_result", result, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done || busy) seen++;
            tick();
        end
        check("mid_rst_quiet", 32'(seen), 32'd0);

        run("mulhu_small", 3'b011, 32'd3, 32'd5, 32'd0, 33);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
